hex_ascii_to_bin: RTL and testbench
===================================

# hex_ascii_to_bin

Streaming parser that converts ASCII hexadecimal text back into binary words, the inverse of the processor's binary-to-hex-ASCII display path. Characters arrive one per handshake from a UART/debug console. The block accumulates up to `DIGITS` hex digits and emits a right-aligned binary word with a digit count. It sits between the character receiver and the debug/memory-load logic, for example register pokes and instruction loading.

## Interface
- `DIGITS`, default 8: maximum hex digits per word. Output width `W = 4*DIGITS`; count width `CW = $clog2(DIGITS+1)`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `char_in`  in  8  ASCII character.
- `char_valid`  in  1  `char_in` is valid.
- `char_ready`  out  1  parser can accept a character this cycle.
- `word_out`  out  W  parsed value, right-aligned, zero-extended.
- `word_digits`  out  CW  number of digits that formed `word_out` (1..DIGITS).
- `word_valid`  out  1  `word_out` and `word_digits` are valid.
- `word_ready`  in  1  consumer accepts the word.
- `err`  out  1  one-cycle pulse when an illegal character is consumed.

## Operation
- **Character accept:** occurs on a rising edge with `char_valid && char_ready`.
- **`char_ready`:** equals `!word_valid`. No characters are accepted while a word is pending.
- **Character classes:**
  - Digit: `'0'-'9'` (0x30-0x39), `'A'-'F'` (0x41-0x46), `'a'-'f'` (0x61-0x66). Converts to a nibble 0-15.
  - Terminator: LF 0x0A, CR 0x0D, space 0x20.
  - Illegal: every other code.
- **Internal state:** accumulator `acc[W-1:0]` and digit counter `cnt[CW-1:0]`. There are two states:
  - COLLECT: `word_valid=0`.
  - HOLD: `word_valid=1`.
- **Digit accepted in COLLECT:** `acc <= {acc[W-5:0], nibble}`, `cnt <= cnt+1`.
  - If the new count equals `DIGITS`, the block auto-emits: load the output registers with the new `acc` and count `DIGITS`, clear `acc`/`cnt`, and go to HOLD.
- **Terminator accepted with `cnt>0`:** emit `acc`/`cnt`, clear `acc`/`cnt`, go to HOLD.
- **Terminator accepted with `cnt==0`:** ignored. Consecutive separators and CR+LF never produce empty words.
- **Illegal character accepted:**
  - `err` pulses high for the following cycle.
  - `acc`/`cnt` clear and the partial word is discarded.
  - Parsing continues in COLLECT. No word is emitted.
- **HOLD → COLLECT:** on a rising edge with `word_ready=1`. `word_valid` drops the next cycle.
  - `word_out`/`word_digits` remain stable throughout HOLD.
- **Leading zeros:** count as digits. For example, `"0001"` gives `word_out=1`, `word_digits=4`.

## Timing
- **Reset (async assert):** `word_valid=0`, `word_out=0`, `word_digits=0`, `err=0`, `acc=0`, `cnt=0`, state COLLECT. `char_ready=1` from the first cycle after reset.
- **Reset mid-word or mid-HOLD:** the partial or pending word is lost. No output is produced after release until new input arrives.
- **Latency:** `word_valid` rises one cycle after the accepting edge of the final digit or terminator. `err` rises one cycle after the accepting edge of the illegal character.
- **Throughput:**
  - One character per cycle while in COLLECT.
  - After an emit, `char_ready` is low for at least one cycle, or until `word_ready` is seen.
  - With `word_ready` tied high, the minimum word period is (digits + 1 terminator) cycles, plus one HOLD cycle.
- **`word_ready` outside HOLD:** has no effect.
- **`char_valid` while `char_ready=0`:** the character is not consumed. The source must hold it (valid/ready rules: valid must not drop before ready).
- **`err` and HOLD:** `err` and an emit never occur from the same character. `err` never asserts while in HOLD, because no character is accepted there.

## Test plan
- Stream `"DEADBEEF"` at one character per cycle with `word_ready=1`. Require `word_valid` one cycle after the 8th `'F'`, with `word_out=0xDEADBEEF` and `word_digits=8`. A following `'\n'` produces no word.
- Stream `"1a\r\n"`. Require exactly one word: `0x0000001A`, `word_digits=2`. `err` never asserts.
- Stream `"12G4\n"`. Require an `err` pulse exactly one cycle after `'G'` is accepted, and no word for `"12"`. The single output word is `0x00000004`, `word_digits=1`.
- Backpressure: send `"ABC "` with `word_ready=0` for 5 cycles after `word_valid`.
  - `char_ready` must stay 0 and `word_out=0xABC` must stay stable during HOLD.
  - Raise `word_ready`. `word_valid` falls the next cycle and `char_ready` returns to 1.
- Send `"  \n\r "` only. Require `word_valid` never asserts and `err` never asserts.
- Send `"123"`, then pulse `rst_n` low asynchronously between clock edges. All outputs must go to their reset values immediately. Then send `"5\n"` and require `word_out=0x5`, `word_digits=1`, with no residue from `"123"`.

Source files
------------

// File: rtl/hex_ascii_to_bin_if.sv
// ---------------------------------------------------------------------------
// hex_ascii_to_bin_if
//
// Character-in / word-out handshake bundle for the hex ASCII parser.
//
//   char_in[7:0]      ASCII character from the receiver
//   char_valid        char_in is valid
//   char_ready        parser can take a character this cycle
//   word_out[W-1:0]   parsed value, right-aligned, zero-extended
//   word_digits[CW-1:0] digit count that formed word_out (1..DIGITS)
//   word_valid        word_out / word_digits are valid
//   word_ready        consumer accepts the word
//   err               one-cycle pulse after an illegal character is consumed
//
// Modports: master = character source / word consumer, slave = parser.
// ---------------------------------------------------------------------------
interface hex_ascii_to_bin_if #(
    parameter int DIGITS = 8
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic [7:0]    char_in;
    logic          char_valid;
    logic          char_ready;
    logic [W-1:0]  word_out;
    logic [CW-1:0] word_digits;
    logic          word_valid;
    logic          word_ready;
    logic          err;

    modport master (
        output char_in, char_valid, word_ready,
        input  char_ready, word_out, word_digits, word_valid, err
    );

    modport slave (
        input  char_in, char_valid, word_ready,
        output char_ready, word_out, word_digits, word_valid, err
    );
endinterface

// File: rtl/hex_ascii_to_bin.sv
// ---------------------------------------------------------------------------
// hex_ascii_to_bin
//
// Streaming parser turning ASCII hex text into right-aligned binary words.
// Digits (0-9, A-F, a-f) shift into an accumulator; a terminator (LF, CR,
// space) or the DIGITS-th digit emits the word and holds it until the
// consumer takes it. Any other character pulses err and drops the partial
// word.
//
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     hex_ascii_to_bin_if.slave (character in, word out, err)
// ---------------------------------------------------------------------------
module hex_ascii_to_bin #(
    parameter int DIGITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    hex_ascii_to_bin_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        CLS_DIGIT,
        CLS_TERM,
        CLS_ILLEGAL
    } char_class_t;

    state_t        state, state_n;
    logic [W-1:0]  acc, acc_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0]  word_r, word_n;
    logic [CW-1:0] digits_r, digits_n;
    logic          err_r, err_n;

    char_class_t   cls;
    logic [3:0]    nibble;
    logic [W-1:0]  acc_shift;
    logic [CW-1:0] cnt_inc;

    // Character classification and nibble decode.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        cls    = CLS_ILLEGAL;
        nibble = 4'h0;
        if (bus.char_in >= 8'h30 && bus.char_in <= 8'h39) begin
            cls    = CLS_DIGIT;
            nibble = bus.char_in[3:0];
        end else if ((bus.char_in >= 8'h41 && bus.char_in <= 8'h46) ||
                     (bus.char_in >= 8'h61 && bus.char_in <= 8'h66)) begin
            // Letters have low nibble 1..6 in both cases; +9 maps to 10..15.
            cls    = CLS_DIGIT;
            nibble = bus.char_in[3:0] + 4'd9;
        end else if (bus.char_in == 8'h0A || bus.char_in == 8'h0D ||
                     bus.char_in == 8'h20) begin
            cls = CLS_TERM;
        end
    end

    assign acc_shift = (acc << 4) | W'(nibble);
    assign cnt_inc   = cnt + CW'(1);

    // Next-state / datapath logic.
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        cnt_n    = cnt;
        word_n   = word_r;
        digits_n = digits_r;
        err_n    = 1'b0;

        case (state)
            COLLECT: begin
                if (bus.char_valid) begin
                    case (cls)
                        CLS_DIGIT: begin
                            if (cnt_inc == CW'(DIGITS)) begin
                                // Word is full: emit without waiting for a terminator.
                                word_n   = acc_shift;
                                digits_n = cnt_inc;
                                acc_n    = '0;
                                cnt_n    = '0;
                                state_n  = HOLD;
                            end else begin
                                acc_n = acc_shift;
                                cnt_n = cnt_inc;
                            end
                        end
                        CLS_TERM: begin
                            // Empty separators (repeated spaces, CR+LF) are swallowed.
                            if (cnt != '0) begin
                                word_n   = acc;
                                digits_n = cnt;
                                acc_n    = '0;
                                cnt_n    = '0;
                                state_n  = HOLD;
                            end
                        end
                        default: begin
                            err_n = 1'b1;
                            acc_n = '0;
                            cnt_n = '0;
                        end
                    endcase
                end
            end
            HOLD: begin
                if (bus.word_ready) begin
                    state_n = COLLECT;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= COLLECT;
            acc      <= '0;
            cnt      <= '0;
            word_r   <= '0;
            digits_r <= '0;
            err_r    <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            word_r   <= word_n;
            digits_r <= digits_n;
            err_r    <= err_n;
        end
    end

    assign bus.word_valid  = (state == HOLD);
    assign bus.char_ready  = (state == COLLECT);
    assign bus.word_out    = word_r;
    assign bus.word_digits = digits_r;
    assign bus.err         = err_r;
endmodule

// File: tb/tb_hex_ascii_to_bin.sv
// ---------------------------------------------------------------------------
// tb_hex_ascii_to_bin
//
// Directed scenarios plus randomized character streams. A behavioural model
// (digit queue, word value built by arithmetic) predicts the outputs each
// cycle; a monitor records emitted words for literal expectations.
// ---------------------------------------------------------------------------
module tb_hex_ascii_to_bin;
    localparam int DIGITS = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hex_ascii_to_bin_if #(.DIGITS(DIGITS)) bus ();

    hex_ascii_to_bin #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // word_ready source: either a fixed level or a random bit per cycle.
    bit   wr_rand   = 1'b0;
    bit   wr_manual = 1'b1;
    bit   rnd_bit   = 1'b0;
    always_comb bus.word_ready = wr_rand ? rnd_bit : wr_manual;
    initial forever begin
        @(posedge clk);
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // ---------------- behavioural model ----------------
    string hx_u = "0123456789ABCDEF";
    string hx_l = "0123456789abcdef";

    function automatic int hexval(logic [7:0] c);
        for (int i = 0; i < 16; i++) begin
            if (c == hx_u[i] || c == hx_l[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit is_term(logic [7:0] c);
        return (c == 8'h0A) || (c == 8'h0D) || (c == 8'h20);
    endfunction

    bit          m_hold   = 1'b0;
    bit          m_err    = 1'b0;
    logic [31:0] m_word   = '0;
    logic [3:0]  m_digits = '0;
    int          digs[$];
    int          m_nib;
    longint      m_val;

    task automatic model_emit();
        m_val = 0;
        foreach (digs[i]) m_val = m_val * 16 + digs[i];
        m_word   = m_val[31:0];
        m_digits = 4'(digs.size());
        digs.delete();
        m_hold = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold   = 1'b0;
            m_err    = 1'b0;
            m_word   = '0;
            m_digits = '0;
            digs.delete();
        end else begin
            m_err = 1'b0;
            if (m_hold) begin
                if (bus.word_ready) m_hold = 1'b0;
            end else if (bus.char_valid) begin
                m_nib = hexval(bus.char_in);
                if (m_nib >= 0) begin
                    digs.push_back(m_nib);
                    if (digs.size() == DIGITS) model_emit();
                end else if (is_term(bus.char_in)) begin
                    if (digs.size() > 0) model_emit();
                end else begin
                    m_err = 1'b1;
                    digs.delete();
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("word_valid",  64'(bus.word_valid),  64'(m_hold));
        check("char_ready",  64'(bus.char_ready),  64'(!m_hold));
        check("err",         64'(bus.err),         64'(m_err));
        check("word_out",    64'(bus.word_out),    64'(m_word));
        check("word_digits", 64'(bus.word_digits), 64'(m_digits));
    end

    // ---------------- monitor ----------------
    typedef struct {
        logic [31:0] w;
        logic [3:0]  d;
    } word_t;

    word_t got[$];
    int    err_seen = 0;
    bit    prev_v   = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (bus.word_valid && !prev_v) got.push_back('{bus.word_out, bus.word_digits});
            if (bus.err) err_seen++;
            prev_v = bus.word_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_char(logic [7:0] c);
        bit rdy;
        int budget = 100;
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        while (1) begin
            rdy = bus.char_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            budget--;
            if (budget == 0) begin
                check("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
        bus.char_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got.delete();
        err_seen = 0;
    endtask

    task automatic expect_one(string name, logic [31:0] w, logic [3:0] d);
        check({name, "_count"}, 64'(got.size()), 64'd1);
        if (got.size() == 1) begin
            check({name, "_word"},   64'(got[0].w), 64'(w));
            check({name, "_digits"}, 64'(got[0].d), 64'(d));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.char_in    = 8'h00;
        bus.char_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state.
        check("rst_word_valid", 64'(bus.word_valid), 64'd0);
        check("rst_char_ready", 64'(bus.char_ready), 64'd1);
        check("rst_word_out",   64'(bus.word_out),   64'd0);
        check("rst_digits",     64'(bus.word_digits), 64'd0);
        check("rst_err",        64'(bus.err),        64'd0);

        // Auto-emit at DIGITS digits; trailing LF yields nothing.
        clear_log();
        send_str("DEADBEEF");
        check("deadbeef_valid",  64'(bus.word_valid),  64'd1);
        check("deadbeef_word",   64'(bus.word_out),    64'hDEADBEEF);
        check("deadbeef_digits", 64'(bus.word_digits), 64'd8);
        send_str("\n");
        idle(6);
        expect_one("deadbeef", 32'hDEADBEEF, 4'd8);
        check("deadbeef_err", 64'(err_seen), 64'd0);

        // CR+LF gives exactly one word.
        clear_log();
        send_str("1a\r\n");
        idle(6);
        expect_one("crlf", 32'h1A, 4'd2);
        check("crlf_err", 64'(err_seen), 64'd0);

        // Illegal character discards the partial word.
        clear_log();
        send_str("12");
        send_char("G");
        check("illegal_err_pulse", 64'(bus.err), 64'd1);
        send_char("4");
        check("illegal_err_gone", 64'(bus.err), 64'd0);
        send_str("\n");
        idle(6);
        expect_one("illegal", 32'h4, 4'd1);
        check("illegal_err_count", 64'(err_seen), 64'd1);

        // Leading zeros count as digits.
        clear_log();
        send_str("0001\n");
        idle(6);
        expect_one("lead0", 32'h1, 4'd4);

        // Backpressure: word held while word_ready is low.
        clear_log();
        wr_manual = 1'b0;
        send_str("ABC ");
        check("bp_valid", 64'(bus.word_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_char_ready", 64'(bus.char_ready), 64'd0);
            check("bp_word",       64'(bus.word_out),   64'hABC);
            check("bp_digits",     64'(bus.word_digits), 64'd3);
        end
        wr_manual = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 64'(bus.word_valid), 64'd0);
        check("bp_release_ready", 64'(bus.char_ready), 64'd1);
        expect_one("bp", 32'hABC, 4'd3);

        // Separators only.
        clear_log();
        send_str("  \n\r ");
        idle(6);
        check("sep_words", 64'(got.size()), 64'd0);
        check("sep_err",   64'(err_seen),   64'd0);

        // Asynchronous reset mid-word.
        clear_log();
        send_str("123");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_word_valid", 64'(bus.word_valid),  64'd0);
        check("arst_word_out",   64'(bus.word_out),    64'd0);
        check("arst_digits",     64'(bus.word_digits), 64'd0);
        check("arst_err",        64'(bus.err),         64'd0);
        check("arst_char_ready", 64'(bus.char_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        check("arst_no_output", 64'(bus.word_valid), 64'd0);
        send_str("5\n");
        idle(6);
        expect_one("arst", 32'h5, 4'd1);

        // Randomized streams with random word_ready.
        wr_rand = 1'b1;
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 60) begin
                string pool;
                pool = "0123456789ABCDEFabcdef";
                send_char(pool[$urandom_range(0, pool.len() - 1)]);
            end else if (r < 75) begin
                string tp;
                tp = "\n\r ";
                send_char(tp[$urandom_range(0, 2)]);
            end else if (r < 85) begin
                send_char(8'($urandom_range(0, 255)));
            end else begin
                bus.char_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.char_valid = 1'b0;
        wr_rand   = 1'b0;
        wr_manual = 1'b1;
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
